mms_stream_ctrl: RTL
====================

# mms_stream_ctrl

Sequencing controller for the team's min/max selector datapath. Accepts a serial stream of unsigned numbers over a valid/ready handshake, groups them into frames, and reduces each frame to its minimum (`select=1`) or maximum (`select=0`) with a single shared comparator and accumulator. Emits one result per frame on a valid/ready output port. It replaces the fixed 4-input combinational selector wherever operands arrive one per cycle.

## Interface
- `WIDTH`, 8, operand and result width; unsigned compare.
- `FRAME_LEN`, 4, beats per frame. Legal range is 1..255; other values are illegal and must trip an elaboration-time check.
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `select`  in  1  1 = min, 0 = max; sampled only on a frame's first accepted beat.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid & in_ready`.
- `in_data`  in  WIDTH  operand.
- `in_last`  in  1  early frame terminator; ends the frame on this beat.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  WIDTH  frame min/max.
- `out_count`  out  8  number of beats in the reported frame (1..FRAME_LEN).

## Operation
- FSM states: IDLE, ACCUM, HOLD. Reset state is IDLE.
- `in_ready = !rst && (state != HOLD)`.
- IDLE, on accepted beat:
  - `acc <= in_data`, `mode <= select`, `cnt <= 1`.
  - Go to HOLD if `in_last` or `FRAME_LEN==1`; otherwise go to ACCUM.
- ACCUM, on accepted beat:
  - `acc <= mode ? min(acc,in_data) : max(acc,in_data)`, `cnt <= cnt+1`.
  - Go to HOLD if `in_last` or `cnt+1 == FRAME_LEN`.
- ACCUM with no beat: hold all state. Bubbles are allowed mid-frame.
- HOLD: `out_valid=1`, `out_data=acc`, `out_count=cnt`; these stay stable until `out_ready`. On `out_valid & out_ready`, go to IDLE.
- Compare is strict. On a tie the accumulator keeps its current value, which is value-identical to the new operand.
- `select` changes after the first beat do not affect the frame in progress.
- `in_last` is ignored if the beat is not accepted.
- `cnt` never wraps: the frame closes at FRAME_LEN regardless of `in_last`.
- Reset mid-frame or in HOLD discards the partial frame or the pending result. No result is emitted for it.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_count=0`, `in_ready=0` while `rst=1`. `in_ready=1` on the first cycle after reset is released.
- Latency: `out_valid` rises the cycle after the closing beat is accepted.
- `in_ready` is 0 throughout HOLD and returns to 1 the cycle after the output handshake.
- Peak throughput is one frame per FRAME_LEN+1 cycles, with `out_ready` tied high.
- In HOLD, `out_data` and `out_count` must not change while `out_valid & !out_ready`.
- All outputs are registered or decoded from state only, except for the `!rst` term in `in_ready`. There is no combinational path from `in_*` to `out_*`.

## Configuration
- `MMS_ARGIDX_EN` defined:
  - Adds an output port `out_index` (8 bits): the zero-based beat position of the winning operand within the frame.
  - Ties resolve to the earliest position for both min and max.
  - `out_index` resets to 0 and is held stable in HOLD with `out_data`.
- `MMS_ARGIDX_EN` undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- **Max frame:** FRAME_LEN=4, `select=0`, beats 0x12, 0xF0, 0x07, 0x80 back-to-back → one cycle after the 4th beat, `out_valid=1`, `out_data=0xF0`, `out_count=4`; with `MMS_ARGIDX_EN`, `out_index=1`.
- **Min frame with mid-frame toggle:** `select=1` on beat 0, then toggled to 0; beats 0x40, 0x03, 0x03, 0x90 → `out_data=0x03` (min retained); with `MMS_ARGIDX_EN`, `out_index=1` (earliest tie).
- **Early termination and backpressure:** `in_last` on the 2nd beat, 0x05 then 0x09, `select=0` → `out_data=0x09`, `out_count=2`. Hold `out_ready=0` for 5 cycles: outputs stable and `in_ready=0` throughout. On the handshake cycle → IDLE, and `in_ready=1` the next cycle.
- **Bubbles:** FRAME_LEN=3, `in_valid` toggling 1,0,0,1,0,1 with data 0xAA, 0x11, 0xBB on the valid cycles, `select=1` → `out_data=0x11`, `out_count=3`.
- **Reset mid-frame:** 2 of 4 beats accepted, then `rst` for 1 cycle → `out_valid` never rises for the partial frame. A subsequent 4-beat frame of 0x01, 0x02, 0x03, 0x04 with `select=0` → `out_data=0x04`, `out_count=4`.
- **FRAME_LEN=1:** beats 0x7E and 0x3C, `out_ready` held high → two results, 0x7E then 0x3C, each with `out_count=1`, spaced 2 cycles apart.

Source files
------------

// File: rtl/mms_stream_ctrl.sv
// Purpose : serial min/max reducer; one shared comparator folds each frame of beats into a single result.
// Latency : result valid the cycle after a frame's closing beat is accepted.
// Backpr. : in_ready low while a result is held; result and count held stable until out_ready.
//
// Ports:
//   clk, rst         sole clock (rising edge), synchronous active-high reset
//   select           1 = min, 0 = max; captured on a frame's first accepted beat
//   in_valid/in_ready/in_data/in_last   input beat handshake; in_last closes a frame early
//   out_valid/out_ready/out_data/out_count   one result per frame plus its beat count
//   out_index        (only with MMS_ARGIDX_EN) zero-based position of the winning beat
//
// Optional feature macro: MMS_ARGIDX_EN adds out_index and its tracking register.
module mms_stream_ctrl #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             select,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       out_count
`ifdef MMS_ARGIDX_EN
    ,
    output logic [7:0]       out_index
`endif
);

    generate
        if (FRAME_LEN < 1 || FRAME_LEN > 255) begin : g_bad_frame_len
            $error("mms_stream_ctrl: FRAME_LEN must be in 1..255");
        end
    endgenerate

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [7:0] LAST_CNT   = 8'(FRAME_LEN);
    localparam logic       SINGLE_BEAT = (FRAME_LEN == 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic             r_mode;
    logic [7:0]       r_cnt;
`ifdef MMS_ARGIDX_EN
    logic [7:0]       r_idx;
`endif

    logic       w_take;
    logic       w_better;
    logic [7:0] w_cnt_nxt;
    logic       w_close_first;
    logic       w_close_accum;

    assign w_take        = in_valid & in_ready;
    // Strict compare: on a tie the held value (and its earlier position) wins.
    assign w_better      = r_mode ? (in_data < r_acc) : (in_data > r_acc);
    // r_cnt never exceeds FRAME_LEN <= 255, so the increment cannot wrap.
    assign w_cnt_nxt     = r_cnt + 8'd1;
    assign w_close_first = in_last | SINGLE_BEAT;
    assign w_close_accum = in_last | (w_cnt_nxt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_mode  <= 1'b0;
            r_cnt   <= 8'd0;
`ifdef MMS_ARGIDX_EN
            r_idx   <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_acc   <= in_data;
                        r_mode  <= select;
                        r_cnt   <= 8'd1;
`ifdef MMS_ARGIDX_EN
                        r_idx   <= 8'd0;
`endif
                        r_state <= w_close_first ? S_HOLD : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_take) begin
                        if (w_better) begin
                            r_acc <= in_data;
`ifdef MMS_ARGIDX_EN
                            // r_cnt beats already taken, so it is this beat's position.
                            r_idx <= r_cnt;
`endif
                        end
                        r_cnt <= w_cnt_nxt;
                        if (w_close_accum) begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The !rst term is the only non-state input to any output.
    assign in_ready  = !rst && (r_state != S_HOLD);
    assign out_valid = (r_state == S_HOLD);
    assign out_data  = r_acc;
    assign out_count = r_cnt;
`ifdef MMS_ARGIDX_EN
    assign out_index = r_idx;
`endif

endmodule
